// File: rtl/geri_sayac_pkg.sv
// Shared definitions for the geri_sayac countdown timer: state encoding and
// default widths used by the top and the prescaler.
package geri_sayac_pkg;

    localparam int DEF_N     = 5;
    localparam int DEF_PRE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        HOLD = ST_HOLD
    } state_t;

    // True for the states in which a countdown is in progress.
    function automatic logic is_active(input state_t st);
        return (st == RUN) || (st == HOLD);
    endfunction

endpackage

// File: rtl/geri_sayac_prescaler.sv
// Tick divider: one tick every limit+1 enabled cycles. The limit is latched
// on load so later changes on the input do not disturb a run in progress.
module geri_sayac_prescaler
    import geri_sayac_pkg::*;
#(
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PRE_W-1:0] limit,
    input  logic             en,
    input  logic             clr,
    output logic             tick
);

    logic [PRE_W-1:0] cnt_r;
    logic [PRE_W-1:0] lim_r;

    // Phase counter and latched limit; a disabled cycle leaves the phase intact
    // so a paused run resumes exactly where it stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {PRE_W{1'b0}};
            lim_r <= {PRE_W{1'b0}};
        end else if (load) begin
            cnt_r <= {PRE_W{1'b0}};
            lim_r <= limit;
        end else if (clr) begin
            cnt_r <= {PRE_W{1'b0}};
        end else if (en) begin
            if (cnt_r == lim_r) begin
                cnt_r <= {PRE_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(PRE_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Tick is combinational so the count decrements on the same edge the phase wraps.
    always_comb begin
        tick = en && (cnt_r == lim_r);
    end

endmodule

// File: rtl/geri_sayac.sv
// Loadable down-counter with prescaler, pause, abort and optional auto-reload.
// Emits a one-cycle done pulse when the count expires.
module geri_sayac
    import geri_sayac_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     load_val,
    input  logic [PRE_W-1:0] prescale,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             reload,
    output logic [N-1:0]     count,
    output logic             busy,
    output logic             done
);

    localparam logic [N-1:0] ZERO = {N{1'b0}};
    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

    state_t       state_r, state_s;
    logic [N-1:0] count_r, count_s;
    logic         busy_r;
    logic         done_r, done_s;
    logic         pre_load_s, pre_en_s, pre_clr_s, tick_s;

    geri_sayac_prescaler #(
        .PRE_W (PRE_W)
    ) u_pre (
        .clk   (clk),
        .rst   (rst),
        .load  (pre_load_s),
        .limit (prescale),
        .en    (pre_en_s),
        .clr   (pre_clr_s),
        .tick  (tick_s)
    );

    // Next-state, next-count and prescaler control; abort beats pause beats counting.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        done_s     = 1'b0;
        pre_load_s = 1'b0;
        pre_en_s   = 1'b0;
        pre_clr_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (load_val != ZERO) begin
                        count_s    = load_val;
                        pre_load_s = 1'b1;
                        state_s    = RUN;
                    end else begin
                        count_s = ZERO;
                        done_s  = 1'b1;
                    end
                end else begin
                    count_s = count_r;
                end
            end
            RUN, HOLD: begin
                if (abort) begin
                    pre_clr_s = 1'b1;
                    state_s   = IDLE;
                end else if (pause) begin
                    state_s = HOLD;
                end else begin
                    // A HOLD cycle with pause released counts as a normal run cycle.
                    state_s  = RUN;
                    pre_en_s = 1'b1;
                    if (tick_s) begin
                        if (count_r == ONE) begin
                            done_s = 1'b1;
                            if (reload && (load_val != ZERO)) begin
                                count_s = load_val;
                            end else begin
                                count_s = ZERO;
                                state_s = IDLE;
                            end
                        end else begin
                            count_s = count_r - ONE;
                        end
                    end else begin
                        count_s = count_r;
                    end
                end
            end
            default: begin
                state_s = IDLE;
                count_s = ZERO;
            end
        endcase
    end

    // State, count and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            count_r <= ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            busy_r  <= is_active(state_s);
            done_r  <= done_s;
        end
    end

    assign count = count_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_geri_sayac.sv
// Bench for geri_sayac: directed scenarios and random stimulus, all checked
// against a cycles-until-next-decrement reference model.
module tb_geri_sayac;

    localparam int N     = 5;
    localparam int PRE_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     load_val;
    logic [PRE_W-1:0] prescale;
    logic             start, pause, abort, reload;
    logic [N-1:0]     count;
    logic             busy, done;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cnt = 0;

    // Reference model state
    int m_count, m_busy, m_done, m_p, m_wait;

    geri_sayac #(.N(N), .PRE_W(PRE_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .load_val (load_val),
        .prescale (prescale),
        .start    (start),
        .pause    (pause),
        .abort    (abort),
        .reload   (reload),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_count = 0; m_busy = 0; m_done = 0; m_p = 0; m_wait = 0;
    endtask

    // One clock edge of the timer's rules, using the inputs sampled at that edge.
    task automatic model_step();
        m_done = 0;
        if (m_busy == 0) begin
            if (start) begin
                if (int'(load_val) != 0) begin
                    m_count = int'(load_val);
                    m_p     = int'(prescale);
                    m_wait  = m_p + 1;
                    m_busy  = 1;
                end else begin
                    m_count = 0;
                    m_done  = 1;
                end
            end
        end else if (abort) begin
            m_busy = 0;
        end else if (!pause) begin
            m_wait--;
            if (m_wait == 0) begin
                m_wait = m_p + 1;
                if (m_count == 1) begin
                    m_done = 1;
                    if (reload && int'(load_val) != 0) m_count = int'(load_val);
                    else begin
                        m_count = 0;
                        m_busy  = 0;
                    end
                end else begin
                    m_count--;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        check("count", int'(count), m_count);
        check("busy", int'(busy), m_busy);
        check("done", int'(done), m_done);
        if (busy) busy_cnt++;
    endtask

    task automatic quiet();
        start = 1'b0; pause = 1'b0; abort = 1'b0; reload = 1'b0;
    endtask

    task automatic run_until_count(input int tgt, input string tag);
        int k;
        k = 0;
        while (int'(count) != tgt && k < 200) begin
            cycle();
            k++;
        end
        if (int'(count) != tgt) check(tag, int'(count), tgt);
    endtask

    task automatic run_until_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 400) begin
            cycle();
            k++;
        end
        if (busy) check(tag, int'(busy), 0);
    endtask

    task automatic launch(input int l, input int p);
        load_val = N'(l);
        prescale = PRE_W'(p);
        start    = 1'b1;
        cycle();
        start    = 1'b0;
    endtask

    initial begin
        int done_at;
        quiet();
        load_val = '0;
        prescale = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_count", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;

        // L=5, P=0: one decrement per cycle
        launch(5, 0);
        check("t1_start", int'(count), 5);
        for (int i = 1; i <= 5; i++) begin
            cycle();
            check("t1_seq", int'(count), 5 - i);
            check("t1_busy", int'(busy), (i < 5) ? 1 : 0);
            check("t1_done", int'(done), (i == 5) ? 1 : 0);
        end
        cycle();
        check("t1_done_gone", int'(done), 0);

        // L=3, P=2; prescale changed mid-run has no effect
        launch(3, 2);
        prescale = '0;
        done_at = -1;
        for (int t = 1; t <= 12; t++) begin
            cycle();
            if (done && done_at < 0) done_at = t;
        end
        check("t2_done_at", done_at, 9);

        // L=6, P=1 with a 4-cycle pause at count 4
        busy_cnt = 0;
        launch(6, 1);
        run_until_count(4, "t3_reach4");
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t3_frozen", int'(count), 4);
        end
        pause = 1'b0;
        run_until_idle("t3_idle");
        check("t3_busy_len", busy_cnt, 16);

        // L=10 abort at 7, then abort+pause together
        launch(10, 0);
        run_until_count(7, "t4_reach7");
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("t4_abort_count", int'(count), 7);
        check("t4_abort_busy", int'(busy), 0);
        repeat (3) cycle();
        check("t4_held", int'(count), 7);
        launch(10, 1);
        repeat (3) cycle();
        abort = 1'b1; pause = 1'b1;
        cycle();
        quiet();
        check("t4_abort_wins", int'(busy), 0);
        cycle();

        // Auto-reload L=3, P=0, then drop reload
        reload = 1'b1;
        launch(3, 0);
        for (int i = 1; i <= 6; i++) begin
            cycle();
            check("t5_seq", int'(count), (i % 3 == 0) ? 3 : 3 - (i % 3));
            check("t5_done", int'(done), (i % 3 == 0) ? 1 : 0);
        end
        reload = 1'b0;
        run_until_idle("t5_idle");
        check("t5_final", int'(count), 0);

        // L=0 start, then immediate restart while done is high
        launch(0, 0);
        check("t6_zero_done", int'(done), 1);
        check("t6_zero_busy", int'(busy), 0);
        launch(2, 0);
        check("t6_restart", int'(busy), 1);
        run_until_idle("t6_idle");

        // Async reset mid-run at count 12
        launch(20, 0);
        run_until_count(12, "t7_reach12");
        #2 rst = 1'b1;
        #1;
        check("t7_rst_count", int'(count), 0);
        check("t7_rst_busy", int'(busy), 0);
        check("t7_rst_done", int'(done), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom % 4) == 0;
            pause    = ($urandom % 8) == 0;
            abort    = ($urandom % 24) == 0;
            reload   = ($urandom % 3) == 0;
            prescale = PRE_W'($urandom % 4);
            load_val = (($urandom % 8) == 0) ? '0 : N'($urandom % 32);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/geri_sayac.md
# geri_sayac

Loadable down-counter (countdown timer) with prescaler, pause, abort and optional auto-reload; the counterpart of the free-running up-counter used elsewhere in the lab designs. A start strobe loads a value and the block counts it down to zero, reports progress on `count`, and emits a one-cycle `done` pulse on expiry. It sits beside the up-counters as the event/delay generator for FSM labs: timeouts, blink periods, debounce windows.

## Interface
- `N`, 5, width of count and load value
- `PRE_W`, 4, width of prescale field

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `load_val`  in  N  countdown start value, sampled on accepted `start` and on each auto-reload
- `prescale`  in  PRE_W  tick divider P; one decrement every P+1 cycles; sampled on accepted `start` only
- `start`  in  1  level-sampled; accepted only in IDLE
- `pause`  in  1  freeze while high (RUN/HOLD)
- `abort`  in  1  cancel run, return to IDLE
- `reload`  in  1  auto-reload mode, sampled at each expiry
- `count`  out  N  current remaining count
- `busy`  out  1  high in RUN or HOLD
- `done`  out  1  one-cycle expiry pulse

## Operation
- Reset (async, any time, including mid-run): state=IDLE, `count`=0, `busy`=0, `done`=0, prescale counter=0, latched prescale=0.
- States: IDLE, RUN, HOLD.
- IDLE: `count` holds last value. `start`=1 with `load_val`≠0 -> `count`=`load_val`, latch `prescale`, prescale counter=0, go RUN. `start`=1 with `load_val`=0 -> stay IDLE, `count`=0, `done` pulses next cycle. `abort`/`pause` ignored in IDLE; `start`+`abort` in IDLE: start accepted.
- RUN, priority abort > pause > count: `abort` -> IDLE, `count` frozen, no `done`. `pause` -> HOLD, no prescale advance that cycle. Otherwise prescale counter increments; at counter==latched P it clears and a tick occurs: `count`-1.
- Expiry: tick with `count`==1 -> `done`=1 for that one cycle. `reload`=0: `count`=0, go IDLE. `reload`=1: `count`=`load_val` (fresh sample; if 0, go IDLE with `count`=0), stay RUN, prescale counter 0.
- HOLD: `abort` -> IDLE; `pause`=0 -> RUN; prescale counter and `count` retained (resume is exact, no lost or extra cycles).
- `start` in RUN/HOLD ignored (no restart). Changes to `prescale` during a run have no effect.
- `count` never wraps below 0; N-bit arithmetic, max load 2^N−1.

## Timing
- All outputs registered; change only on `clk` rising edge or async `rst`.
- `start` accepted at edge k: `busy`=1, `count`=L after edge k.
- First decrement at edge k+P+1; n-th at k+n(P+1).
- `done` high during the cycle after edge k+L(P+1); `busy` low from that same edge (non-reload). Busy duration = L(P+1) cycles plus pause cycles.
- `start` may be re-accepted on the cycle `done` is high (state already IDLE).
- Abort/pause take effect at the edge where sampled high.

## Structure
- Shared package: state encoding localparams (IDLE=2'd0, RUN=2'd1, HOLD=2'd2), default widths.
- One sub-module: `geri_sayac_prescaler` (PRE_W counter, enable, clear, latched limit, tick output). Top holds FSM, count register, done pulse.

## Test plan
- N=5, P=0, L=5, start pulse -> `count` 5,4,3,2,1,0 on successive cycles; `done` one cycle after reaching 0 edge; `busy` 5 cycles.
- P=2, L=3 -> decrements every 3 cycles; `done` after 9 cycles; change `prescale` mid-run to 0 -> timing unchanged.
- L=6, P=1, `pause` high 4 cycles at count=4 -> `count` frozen 4 cycles; `done` 4 cycles later than unpaused.
- L=10, `abort` at count=7 -> IDLE, `count` stays 7, no `done`; `abort`+`pause` together -> abort wins.
- `reload`=1, L=3, P=0 -> `count` 3,2,1,3,2,1…, `done` every 3 cycles; drop `reload` -> stops at 0.
- L=0 start -> no busy, `done` pulse next cycle; async `rst` mid-run at count=12 -> immediate `count`=0, `busy`=0, `done`=0.
